// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the two-port instruction-ROM arbiter.
package rom_port_arbiter_pkg;

  // Which requester owns the ROM read port in the current cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_LD   = 2'd2
  } sel_e;

  // Default number of consecutive denied load cycles before the load port wins.
  localparam int STARVE_LIMIT_DEF = 4;

  // Width of addresses and data words on both ports and on the ROM.
  localparam int DATA_W = 32;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle of the fetch port, load port and ROM read port signals.
interface rom_port_arbiter_if;
  import rom_port_arbiter_pkg::*;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ld_req;
  logic [DATA_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;

  logic [DATA_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, rom_data,
    output if_gnt, if_rvalid, if_rdata,
    output ld_gnt, ld_rvalid, ld_rdata, ld_err,
    output rom_addr
  );

  // Requesters plus ROM side.
  modport master (
    output if_req, if_addr, ld_req, ld_addr, rom_data,
    input  if_gnt, if_rvalid, if_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata, ld_err,
    input  rom_addr
  );

endinterface

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive cycles the load port was denied.
module rom_arb_starve_ctr
  import rom_port_arbiter_pkg::*;
#(
  parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int CW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_req_i,
  input  logic          ld_gnt_i,
  output logic [CW-1:0] cnt_o,
  output logic          at_limit_o
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // A grant clears the count; a denied request bumps it up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_gnt_i) begin
      cnt_d = '0;
    end else if (ld_req_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates a fetch port and a load port onto one combinational ROM read port.
// Fetch has priority unless the load port has been starved for STARVE_LIMIT cycles.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  rom_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  sel_e              sel;
  logic              ld_bad;
  logic [CW-1:0]     starve_cnt;
  logic              starve_full;

  logic              if_rvalid_q, if_rvalid_d;
  logic              ld_rvalid_q, ld_rvalid_d;
  logic              ld_err_q,    ld_err_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q,  ld_rdata_d;

  rom_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .ld_req_i   (bus.ld_req),
    .ld_gnt_i   (bus.ld_gnt),
    .cnt_o      (starve_cnt),
    .at_limit_o (starve_full)
  );

  // Port select; nothing is granted while reset is held low.
  always_comb begin
    sel = SEL_NONE;
    if (reset) begin
      if (bus.ld_req && (!bus.if_req || starve_full)) begin
        sel = SEL_LD;
      end else if (bus.if_req) begin
        sel = SEL_IF;
      end
    end
  end

  assign bus.if_gnt = (sel == SEL_IF);
  assign bus.ld_gnt = (sel == SEL_LD);

  // Route the granted address to the ROM, zero when idle.
  always_comb begin
    bus.rom_addr = '0;
    case (sel)
      SEL_IF:  bus.rom_addr = bus.if_addr;
      SEL_LD:  bus.rom_addr = bus.ld_addr;
      default: bus.rom_addr = '0;
    endcase
  end

  // Loads must be word aligned and land inside the 2**ADDR_WIDTH word ROM.
  assign ld_bad = (bus.ld_addr[1:0] != 2'b00) ||
                  ((bus.ld_addr >> (ADDR_WIDTH + 2)) != '0);

  // Response next-state: one-cycle valid pulse, data held between responses.
  always_comb begin
    if_rvalid_d = bus.if_gnt;
    ld_rvalid_d = bus.ld_gnt;
    ld_err_d    = bus.ld_gnt && ld_bad;
    if_rdata_d  = if_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    if (bus.if_gnt) begin
      if_rdata_d = bus.rom_data;
    end
    if (bus.ld_gnt) begin
      ld_rdata_d = ld_bad ? '0 : bus.rom_data;
    end
  end

  // Response registers; reset drops any in-flight response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rvalid_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      ld_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_rvalid_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_err_q    <= ld_err_d;
      if_rdata_q  <= if_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter with a behavioural ROM.
module tb_rom_port_arbiter;

  localparam int AW  = 8;
  localparam int LIM = 4;

  logic clock;
  logic reset;

  rom_port_arbiter_if bus ();

  rom_port_arbiter #(
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          ld;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int          nchk;
  int          nerr;
  int          m_cnt;
  logic [31:0] last_if;
  logic [31:0] last_ld;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
    return {idx ^ 8'h3C, 8'hA5, ~idx, idx};
  endfunction

  // Behavioural ROM, indexed by word.
  always_comb bus.rom_data = rom_word(bus.rom_addr[AW+1:2]);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ld_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  task automatic check_resp();
    exp_t e;
    bit   has;
    has = (sb.size() > 0);
    if (has) e = sb.pop_front();
    check_val("if_rvalid", bus.if_rvalid, (has && !e.ld) ? 1 : 0);
    check_val("ld_rvalid", bus.ld_rvalid, (has && e.ld) ? 1 : 0);
    check_val("ld_err", bus.ld_err, (has && e.ld && e.err) ? 1 : 0);
    if (has && !e.ld) last_if = e.data;
    if (has && e.ld)  last_ld = e.data;
    check_val("if_rdata", bus.if_rdata, last_if);
    check_val("ld_rdata", bus.ld_rdata, last_ld);
  endtask

  // One clock cycle: drive requests, check grant, push expected response, check it next edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la);
    exp_t        e;
    bit          win_ld;
    bit          win_if;
    logic [31:0] eaddr;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.ld_req  = lr;
    bus.ld_addr = la;
    #1;
    win_ld = lr && (!ir || m_cnt == LIM);
    win_if = ir && !win_ld;
    eaddr  = win_ld ? la : (win_if ? ia : 32'd0);
    check_val("if_gnt", bus.if_gnt, win_if ? 1 : 0);
    check_val("ld_gnt", bus.ld_gnt, win_ld ? 1 : 0);
    check_val("rom_addr", bus.rom_addr, eaddr);
    if (win_if) begin
      e.ld = 0; e.err = 0; e.data = rom_word(ia[AW+1:2]);
      sb.push_back(e);
    end
    if (win_ld) begin
      e.ld = 1; e.err = ld_bad(la);
      e.data = e.err ? 32'd0 : rom_word(la[AW+1:2]);
      sb.push_back(e);
    end
    if (win_ld) m_cnt = 0;
    else if (lr && m_cnt < LIM) m_cnt++;
    @(posedge clock);
    #1;
    check_resp();
    check_val("starve_cnt", 32'(dut.starve_cnt), m_cnt);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_if_gnt"}, bus.if_gnt, 0);
    check_val({pfx, "_ld_gnt"}, bus.ld_gnt, 0);
    check_val({pfx, "_rom_addr"}, bus.rom_addr, 0);
    check_val({pfx, "_if_rvalid"}, bus.if_rvalid, 0);
    check_val({pfx, "_ld_rvalid"}, bus.ld_rvalid, 0);
    check_val({pfx, "_ld_err"}, bus.ld_err, 0);
    check_val({pfx, "_if_rdata"}, bus.if_rdata, 0);
    check_val({pfx, "_ld_rdata"}, bus.ld_rdata, 0);
    check_val({pfx, "_starve"}, 32'(dut.starve_cnt), 0);
  endtask

  initial begin
    nchk = 0; nerr = 0; m_cnt = 0;
    last_if = '0; last_ld = '0;
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h20;
    #3;
    check_all_zero("rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Lone fetch, first cycle out of reset.
    step(1, 32'h10, 0, 32'h0);
    // Lone aligned load.
    step(0, 32'h0, 1, 32'h20);
    // Idle: data must hold.
    step(0, 32'h0, 0, 32'h0);

    // Contention: F F F F L repeating.
    for (int i = 0; i < 10; i++) step(1, 32'h100 + 4 * i, 1, 32'h200 + 4 * i);

    // Load errors: out of range and misaligned.
    step(0, 32'h0, 1, 32'h402);
    step(0, 32'h0, 1, 32'h401);
    step(0, 32'h0, 1, 32'h400);
    step(0, 32'h0, 1, 32'h3FC);
    // Fetch with high bits set is not checked.
    step(1, 32'hFFFF_F008, 0, 32'h0);

    // Back-to-back alternating lone fetch and lone load.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 32'h40 + 8 * i, 0, 32'h0);
      else            step(0, 32'h0, 1, 32'h80 + 8 * i);
    end

    // Build up some starvation, then reset mid-transaction.
    step(1, 32'h30, 1, 32'h34);
    step(1, 32'h38, 1, 32'h3C);
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.ld_req = 1'b0; bus.ld_addr = 32'h0;
    #1;
    check_val("mid_if_gnt", bus.if_gnt, 1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("mid");
    @(posedge clock);
    #1;
    check_val("mid_post_if_rvalid", bus.if_rvalid, 0);
    check_val("mid_post_ld_rvalid", bus.ld_rvalid, 0);
    @(negedge clock);
    bus.if_req = 1'b0;
    bus.ld_req = 1'b0;
    reset = 1'b1;
    sb.delete();
    m_cnt = 0; last_if = '0; last_ld = '0;
    step(0, 32'h0, 0, 32'h0);
    step(0, 32'h0, 1, 32'h14);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      logic        ir, lr;
      logic [31:0] ia, la;
      ir = 1'($urandom_range(0, 1));
      lr = 1'($urandom_range(0, 1));
      ia = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 8'($urandom), 2'b00};
      la = {22'd0, 8'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) la = la | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) la = la | 32'h0000_0400;
      step(ir, ia, lr, la);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
